// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register file write port between ALU and load writeback
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt1,
  input  logic                  stall,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]   wr_dec,
  output logic                  prio
);
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  live;
  always_comb begin
    gnt0 = reset && !stall && req0 && (!req1 || !prio);
    gnt1 = reset && !stall && req1 && (!req0 || prio);
    addr_w = gnt1 ? addr1 : addr0;
    data_w = gnt1 ? data1 : data0;
    live = addr_w != ADDR_WIDTH'(ZERO_REG);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_dec <= '0;
      prio <= 1'b0;
    end else if (gnt0 || gnt1) begin
      prio <= gnt0;
      wr_addr <= addr_w;
      wr_data <= data_w;
      wr_en <= live;
      wr_dec <= live ? {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_w : '0;
    end else begin
      wr_en <= 1'b0;
      wr_dec <= '0;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed-vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  logic        clk = 0, reset = 0, req0 = 0, req1 = 0, stall = 0;
  logic [4:0]  addr0 = 0, addr1 = 0;
  logic [63:0] data0 = 0, data1 = 0;
  logic        gnt0, gnt1, wr_en, prio;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] wr_dec;
  int vectors = 0, miscompares = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dec(wr_dec), .prio(prio)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 0; req0 = 1; req1 = 1; addr0 = 7; data0 = 70; addr1 = 9; data1 = 90;
    #1;
    vectors++; if ({gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1}); end
    vectors++; if (wr_en !== 1'b0 || wr_dec !== 32'h0) begin miscompares++; $display("FAIL rst_wr: got en=%b dec=%h want 0/0", wr_en, wr_dec); end
    vectors++; if (prio !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 64'd0) begin miscompares++; $display("FAIL rst_state: got prio=%b addr=%0d data=%0d want 0", prio, wr_addr, wr_data); end
    tick();
    vectors++; if (wr_en !== 1'b0 || {gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL rst_held: got en=%b gnt=%b want 0/00", wr_en, {gnt0, gnt1}); end
    reset = 1;
    #1;
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL rst_first_gnt: got %b want 10", {gnt0, gnt1}); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'd70 || wr_dec !== 32'h80) begin miscompares++; $display("FAIL rst_first_wr: got en=%b a=%0d d=%0d dec=%h want 1/7/70/80", wr_en, wr_addr, wr_data, wr_dec); end
    vectors++; if (prio !== 1'b1) begin miscompares++; $display("FAIL rst_prio: got %b want 1", prio); end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_single();
    req0 = 1; addr0 = 3; data0 = 27;
    #1;
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL single_gnt: got %b want 10", {gnt0, gnt1}); end
    tick();
    req0 = 0;
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 64'd27 || wr_dec !== 32'h0000_0008) begin miscompares++; $display("FAIL single_wr: got en=%b a=%0d d=%0d dec=%h want 1/3/27/8", wr_en, wr_addr, wr_data, wr_dec); end
    tick();
    vectors++; if (wr_en !== 1'b0 || wr_dec !== 32'h0 || wr_addr !== 5'd3 || wr_data !== 64'd27) begin miscompares++; $display("FAIL single_idle: got en=%b dec=%h a=%0d d=%0d want 0/0/3/27", wr_en, wr_dec, wr_addr, wr_data); end
    vectors++; if (prio !== 1'b1) begin miscompares++; $display("FAIL single_prio: got %b want 1", prio); end
  endtask

  task automatic test_zero_reg();
    req1 = 1; addr1 = 31; data1 = 64'hFFFF;
    #1;
    vectors++; if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL zero_gnt: got %b want 01", {gnt0, gnt1}); end
    tick();
    req1 = 0;
    vectors++; if (wr_en !== 1'b0 || wr_dec !== 32'h0) begin miscompares++; $display("FAIL zero_wr: got en=%b dec=%h want 0/0", wr_en, wr_dec); end
    vectors++; if (prio !== 1'b0) begin miscompares++; $display("FAIL zero_prio: got %b want 0", prio); end
  endtask

  task automatic test_contention();
    req0 = 1; addr0 = 1; data0 = 10; req1 = 1; addr1 = 2; data1 = 20;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({gnt0, gnt1} !== ((i % 2) ? 2'b01 : 2'b10) || prio !== 1'(i % 2)) begin miscompares++; $display("FAIL cont_gnt%0d: got gnt=%b prio=%b want %b/%0d", i, {gnt0, gnt1}, prio, (i % 2) ? 2'b01 : 2'b10, i % 2); end
      tick();
      vectors++; if (wr_en !== 1'b1 || wr_dec !== ((i % 2) ? 32'h4 : 32'h2) || wr_data !== ((i % 2) ? 64'd20 : 64'd10) || prio !== 1'(~(i % 2))) begin miscompares++; $display("FAIL cont_wr%0d: got en=%b dec=%h d=%0d prio=%b", i, wr_en, wr_dec, wr_data, prio); end
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_stall_collision();
    stall = 1; req0 = 1; req1 = 1; addr0 = 5; addr1 = 5; data0 = 33; data1 = 64'd2147483647;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL stall_gnt%0d: got %b want 00", i, {gnt0, gnt1}); end
      tick();
      vectors++; if (prio !== 1'b0 || wr_en !== 1'b0) begin miscompares++; $display("FAIL stall_state%0d: got prio=%b en=%b want 0/0", i, prio, wr_en); end
    end
    stall = 0;
    #1;
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL coll_gnt0: got %b want 10", {gnt0, gnt1}); end
    tick();
    req0 = 0;
    vectors++; if (wr_en !== 1'b1 || wr_dec !== 32'h20 || wr_data !== 64'd33) begin miscompares++; $display("FAIL coll_wr0: got en=%b dec=%h d=%0d want 1/20/33", wr_en, wr_dec, wr_data); end
    #1;
    vectors++; if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL coll_gnt1: got %b want 01", {gnt0, gnt1}); end
    tick();
    req1 = 0;
    vectors++; if (wr_en !== 1'b1 || wr_dec !== 32'h20 || wr_data !== 64'd2147483647) begin miscompares++; $display("FAIL coll_wr1: got en=%b dec=%h d=%0d want 1/20/2147483647", wr_en, wr_dec, wr_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1; addr0 = 4; data0 = 44;
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_dec !== 32'h10 || prio !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got en=%b dec=%h prio=%b want 1/10/1", wr_en, wr_dec, prio); end
    #1 reset = 0;
    #1;
    vectors++; if (wr_en !== 1'b0 || wr_dec !== 32'h0 || prio !== 1'b0 || wr_data !== 64'd0) begin miscompares++; $display("FAIL mid_async: got en=%b dec=%h prio=%b d=%0d want 0", wr_en, wr_dec, prio, wr_data); end
    vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL mid_gnt_held: got %b want 0", gnt0); end
    tick();
    vectors++; if (wr_en !== 1'b0 || gnt0 !== 1'b0) begin miscompares++; $display("FAIL mid_edge: got en=%b gnt0=%b want 0/0", wr_en, gnt0); end
    reset = 1;
    #1;
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL mid_regrant: got %b want 1", gnt0); end
    tick();
    req0 = 0;
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 64'd44) begin miscompares++; $display("FAIL mid_rewr: got en=%b a=%0d d=%0d want 1/4/44", wr_en, wr_addr, wr_data); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_zero_reg();
    test_contention();
    test_stall_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32 x 64-bit register file between two writeback sources: requester 0 (ALU/execute) and requester 1 (load/memory). Arbitrates round-robin and registers the winning write. Drives a one-hot enable vector; each bit feeds the en input of one 64-bit register in the file. Writes to the zero register are accepted but discarded.

Parameters:
DATA_WIDTH, 64, width of write data
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, number of registers (2**ADDR_WIDTH)
ZERO_REG, 31, index whose writes are dropped (XZR)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req0  input  1  requester 0 write request
addr0  input  ADDR_WIDTH  requester 0 destination register
data0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  grant to requester 0 (combinational)
req1  input  1  requester 1 write request
addr1  input  ADDR_WIDTH  requester 1 destination register
data1  input  DATA_WIDTH  requester 1 write data
gnt1  output  1  grant to requester 1 (combinational)
stall  input  1  register file unavailable; no grants issued
wr_en  output  1  registered write strobe to register file
wr_addr  output  ADDR_WIDTH  registered destination index
wr_data  output  DATA_WIDTH  registered write data
wr_dec  output  NUM_REGS  registered one-hot per-register enable
prio  output  1  current favoured requester (0/1), debug visibility

Behaviour:
- Reset (reset==0, async): wr_en=0, wr_addr=0, wr_data=0, wr_dec=0, prio=0. gnt0=gnt1=0 while reset is held low.
- Grant logic is combinational from req0, req1, prio and stall:
  - If stall=1: gnt0=gnt1=0.
  - Only one req high: grant it.
  - Both high: grant requester == prio.
  - Neither high: no grant.
  - At most one gnt is high in any cycle.
- Handshake: a requester holds req, addr and data stable until a rising edge where its gnt is 1. That edge completes the transfer, and the requester may drop req or present a new request on the next cycle.
- Priority state:
  - On an edge with a grant to k: prio <= ~k.
  - No grant: prio holds.
  - Result: strict alternation under continuous contention, so worst-case wait is 1 cycle.
- Write stage (1-cycle latency): on an edge with a grant to k, wr_addr<=addr_k and wr_data<=data_k.
  - If addr_k != ZERO_REG: wr_en<=1 and wr_dec<=one-hot(addr_k).
  - If addr_k == ZERO_REG: wr_en<=0 and wr_dec<=0. The grant is still issued and the write is silently dropped.
  - On an edge with no grant: wr_en<=0, wr_dec<=0, wr_addr and wr_data hold.
- wr_dec has exactly one bit set iff wr_en=1; otherwise it is all zero.
- Same-address contention: both writes complete in grant order. The register ends with the later-granted value. No merging, no forwarding.
- stall asserted mid-contention: no grant, prio frozen. Arbitration resumes with the same prio once stall drops.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). Any request being held is not granted and must be re-presented after reset deasserts. First grant is at the first rising edge after deassertion.
- Back-to-back: one write per cycle sustained. wr_en may stay high on consecutive cycles.

Test Plan:
- Reset: drive reset=0 with req0=req1=1 -> gnt0=gnt1=0, wr_en=0, wr_dec=0, prio=0. Release reset -> next edge grants req0.
- Single requester: req0=1, addr0=3, data0=27 for one edge -> gnt0=1 that cycle. Next cycle wr_en=1, wr_addr=3, wr_data=27, wr_dec=32'h0000_0008.
- Contention: req0=req1=1 held 4 cycles (addr0=1/data0=10, addr1=2/data1=20) -> grants 0,1,0,1. wr_dec alternates 32'h2, 32'h4. prio toggles each edge.
- Zero register: req1=1, addr1=31, data1=64'hFFFF -> gnt1=1. Next cycle wr_en=0, wr_dec=0. Register file contents unchanged.
- Stall and collision: stall=1 with both requesting -> no grants for 3 cycles, prio unchanged. Then stall=0 with both requesting addr=5 (data0=33, data1=2147483647) -> the prio side is written first, the other next cycle. Final wr_data equals the second-granted value.
- Reset mid-write: pulse reset low between edges while wr_en=1 -> wr_en and wr_dec drop immediately without waiting for a clock edge.
